wbm_lsu_if: RTL and testbench
=============================

Name: wbm_lsu_if

Overview:
- Wishbone master bridging the CPU load/store unit to the data-side Wishbone bus.
- Sits directly upstream of the on-chip memory slave. Converts one CPU request (byte/half/word, big-endian) into one classic Wishbone cycle.
- Generates sel/lane placement, extends read data, and handles ack/err/rty with bounded retry and timeout.
- Reports completion and a status code back to the pipeline.

Parameters:
- TIMEOUT, 255: cycles stb_o may stay high without ack_i/err_i/rty_i before the access is aborted (8-bit counter; legal range 1..255).
- MAX_RETRY, 3: rty_i responses tolerated before the access is failed; retry counter is 2 bits wide.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- req  in  1  CPU request strobe, sampled only in IDLE
- we  in  1  1=store, 0=load
- size  in  2  00 byte, 01 half, 10 word, 11 reserved
- sgn  in  1  load sign-extend (1) / zero-extend (0)
- addr  in  32  byte address
- wdata  in  32  store data, right-justified
- busy  out  1  access in progress (state != IDLE)
- done  out  1  one-cycle completion pulse
- rdata  out  32  extended load data, valid with done
- status  out  2  valid with done: 00 ok, 01 misaligned/illegal size, 10 bus error, 11 timeout
- adr_o  out  32  {addr[31:2],2'b00}
- dat_o  out  32  lane-replicated store data
- dat_i  in  32  slave read data
- we_o  out  1  write enable
- sel_o  out  4  byte lanes; sel_o[3] = dat[31:24] = byte offset 0
- cyc_o, stb_o  out  1 each  bus cycle / strobe
- ack_i, err_i, rty_i  in  1 each  slave termination

Behaviour:
- Reset, asynchronous: state=IDLE; cyc_o=stb_o=we_o=0; sel_o=0; adr_o=dat_o=0; done=0; busy=0; rdata=0; status=00; counters=0.
- A reset mid-cycle drops cyc_o/stb_o immediately. No done is issued for the aborted access.
- All outputs are registered.
- Inputs are latched at acceptance. Input changes while busy are ignored.
- req while busy is ignored, not queued.
- Lane/alignment decode (big-endian):
  - byte: sel = 1000 >> addr[1:0]; dat_o = {4{wdata[7:0]}}.
  - half: legal only if addr[0]=0; sel = addr[1] ? 0011 : 1100; dat_o = {2{wdata[15:0]}}.
  - word: legal only if addr[1:0]=00; sel = 1111; dat_o = wdata.
  - size=11 or misalignment: no bus cycle; done pulses on the cycle after acceptance with status=01 and rdata=0.
- FSM states:
  - IDLE: on req with a legal access -> ACCESS; cyc_o=stb_o=1 from the next cycle; tmo=0.
  - ACCESS: termination priority is err_i > rty_i > ack_i, sampled each edge.
    - ack_i: drop cyc_o/stb_o at that edge. For a load, capture dat_i lanes, extract, and extend to 32 bits per sgn. done=1, status=00 -> IDLE.
    - err_i: drop cyc/stb; done, status=10 -> IDLE.
    - rty_i: drop cyc/stb. If retry count == MAX_RETRY: done, status=10 -> IDLE. Otherwise increment retry count -> BACKOFF.
    - No termination: tmo++. When tmo reaches TIMEOUT: drop cyc/stb; done, status=11 -> IDLE.
  - BACKOFF: one idle cycle with cyc_o=stb_o=0, then reissue the identical cycle -> ACCESS; tmo=0.
- stb_o is deasserted on the edge that samples ack_i. It never stays high into a second ack cycle.
- Latency against a slave that acks one cycle after stb (zero wait): req sampled at edge E0; cyc/stb high E0–E2; ack_i high E1–E2; done high E2–E3. Total is 3 cycles from req to done.
- Each additional slave wait cycle adds 1. Each retry adds 2 plus the slave latency.
- done is high for exactly one cycle. busy falls in the same cycle done rises.
- A new req is accepted while done is high, giving back-to-back accesses with one idle bus cycle between them.
- rdata for stores = 0. rdata holds its last value until the next done.

Test Plan:
- Word store addr=0x0000_0010, wdata=0xDEADBEEF; slave acks 1 cycle after stb -> sel_o=1111, adr_o=0x10, we_o=1; done 3 cycles after req; status=00.
- Byte load addr=0x13 with sgn=1, slave word 0x1122_33F0 -> sel_o=0001; rdata=0xFFFF_FFF0. Repeat with sgn=0 -> 0x0000_00F0.
- Half store addr=0x22, wdata=0x0000_ABCD -> sel_o=0011, dat_o=0xABCD_ABCD. Half load addr=0x21 -> no cyc_o; done next cycle; status=01.
- Slave answers rty_i four times -> three BACKOFF gaps (cyc_o low 1 cycle each), four stb_o assertions; final status=10.
- Slave never responds, TIMEOUT=255 -> stb_o held exactly 255 cycles, then dropped; done with status=11.
- Assert rst while cyc_o=1 -> cyc_o/stb_o low in the same cycle; no done; next req after reset completes normally with status=00.

Source files
------------

// File: rtl/wbm_lsu_if.sv
// Wishbone classic master for the CPU load/store unit: big-endian lane placement,
// load extension, and err/rty/timeout handling with bounded retry.
module wbm_lsu_if #(
  parameter int unsigned TIMEOUT   = 255,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sgn,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic [1:0]  status,
  output logic [31:0] adr_o,
  output logic [31:0] dat_o,
  input  logic [31:0] dat_i,
  output logic        we_o,
  output logic [3:0]  sel_o,
  output logic        cyc_o,
  output logic        stb_o,
  input  logic        ack_i,
  input  logic        err_i,
  input  logic        rty_i
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_BACKOFF} state_t;

  localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT - 1);
  localparam logic [1:0] RETRY_MAX = 2'(MAX_RETRY);

  localparam logic [1:0] ST_OK    = 2'b00;
  localparam logic [1:0] ST_ALIGN = 2'b01;
  localparam logic [1:0] ST_BUS   = 2'b10;
  localparam logic [1:0] ST_TMO   = 2'b11;

  state_t      r_state;
  logic [7:0]  r_tmo;
  logic [1:0]  r_retry;
  logic [1:0]  r_size;
  logic [1:0]  r_off;
  logic        r_sgn;

  logic        w_legal;
  logic [3:0]  w_sel;
  logic [31:0] w_dat;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ext;

  // Request decode: lane select and replicated store data from the live inputs.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    w_legal = 1'b0;
    w_sel   = 4'b0000;
    w_dat   = 32'h0;
    unique case (size)
      2'b00: begin
        w_legal = 1'b1;
        w_sel   = 4'b1000 >> addr[1:0];
        w_dat   = {4{wdata[7:0]}};
      end
      2'b01: begin
        w_legal = ~addr[0];
        w_sel   = addr[1] ? 4'b0011 : 4'b1100;
        w_dat   = {2{wdata[15:0]}};
      end
      2'b10: begin
        w_legal = (addr[1:0] == 2'b00);
        w_sel   = 4'b1111;
        w_dat   = wdata;
      end
      default: ;
    endcase
  end

  // Load extraction from the latched offset/size; byte offset 0 lives in dat_i[31:24].
  always_comb begin
    w_byte = dat_i[31:24];
    unique case (r_off)
      2'b00: w_byte = dat_i[31:24];
      2'b01: w_byte = dat_i[23:16];
      2'b10: w_byte = dat_i[15:8];
      2'b11: w_byte = dat_i[7:0];
    endcase
    w_half = r_off[1] ? dat_i[15:0] : dat_i[31:16];
    unique case (r_size)
      2'b00:   w_ext = {{24{r_sgn & w_byte[7]}}, w_byte};
      2'b01:   w_ext = {{16{r_sgn & w_half[15]}}, w_half};
      default: w_ext = dat_i;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_tmo   <= '0;
      r_retry <= '0;
      r_size  <= '0;
      r_off   <= '0;
      r_sgn   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rdata   <= '0;
      status  <= ST_OK;
      adr_o   <= '0;
      dat_o   <= '0;
      we_o    <= 1'b0;
      sel_o   <= '0;
      cyc_o   <= 1'b0;
      stb_o   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout so every register updates from pre-edge values.
      done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (req) begin
            if (w_legal) begin
              r_size  <= size;
              r_off   <= addr[1:0];
              r_sgn   <= sgn;
              adr_o   <= {addr[31:2], 2'b00};
              dat_o   <= w_dat;
              sel_o   <= w_sel;
              we_o    <= we;
              cyc_o   <= 1'b1;
              stb_o   <= 1'b1;
              busy    <= 1'b1;
              r_tmo   <= '0;
              r_retry <= '0;
              r_state <= S_ACCESS;
            end else begin
              done   <= 1'b1;
              status <= ST_ALIGN;
              rdata  <= '0;
            end
          end
        end
        S_ACCESS: begin
          if (err_i || rty_i || ack_i || (r_tmo == TMO_LAST)) begin
            cyc_o <= 1'b0;
            stb_o <= 1'b0;
          end
          // Termination priority: err > rty > ack > timeout.
          if (err_i || (rty_i && r_retry == RETRY_MAX)) begin
            done    <= 1'b1;
            busy    <= 1'b0;
            status  <= ST_BUS;
            rdata   <= '0;
            r_state <= S_IDLE;
          end else if (rty_i) begin
            r_retry <= r_retry + 2'd1;
            r_state <= S_BACKOFF;
          end else if (ack_i) begin
            done    <= 1'b1;
            busy    <= 1'b0;
            status  <= ST_OK;
            rdata   <= we_o ? 32'h0 : w_ext;
            r_state <= S_IDLE;
          end else if (r_tmo == TMO_LAST) begin
            done    <= 1'b1;
            busy    <= 1'b0;
            status  <= ST_TMO;
            rdata   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_tmo <= r_tmo + 8'd1;
          end
        end
        S_BACKOFF: begin
          cyc_o   <= 1'b1;
          stb_o   <= 1'b1;
          r_tmo   <= '0;
          r_state <= S_ACCESS;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wbm_lsu_if.sv
// Directed bench for wbm_lsu_if with a small slave model selectable between
// ack, retry, error and silent responses.
module tb_wbm_lsu_if;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        sgn = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        busy, done;
  logic [31:0] rdata;
  logic [1:0]  status;
  logic [31:0] adr_o, dat_o;
  logic [31:0] dat_i = '0;
  logic        we_o;
  logic [3:0]  sel_o;
  logic        cyc_o, stb_o;
  logic        ack_i = 1'b0, err_i = 1'b0, rty_i = 1'b0;

  typedef enum int {M_ACK, M_RTY, M_ERR, M_NONE} mode_t;
  mode_t mode = M_ACK;

  int checks = 0;
  int errors = 0;

  // results of the last run() call
  int          lat, stb_rise, stb_hi, gaps;
  logic        cyc_seen;
  logic [3:0]  cap_sel;
  logic [31:0] cap_adr, cap_dat;
  logic        cap_we;
  logic [1:0]  res_status;
  logic [31:0] res_rdata;

  wbm_lsu_if dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .sgn(sgn),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
    .status(status), .adr_o(adr_o), .dat_o(dat_o), .dat_i(dat_i),
    .we_o(we_o), .sel_o(sel_o), .cyc_o(cyc_o), .stb_o(stb_o),
    .ack_i(ack_i), .err_i(err_i), .rty_i(rty_i)
  );

  always #5 clk = ~clk;

  // Slave responds one cycle after it sees stb, for a single cycle.
  always @(posedge clk) begin
    ack_i <= !rst && mode == M_ACK && stb_o && !ack_i;
    rty_i <= !rst && mode == M_RTY && stb_o && !rty_i;
    err_i <= !rst && mode == M_ERR && stb_o && !err_i;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request and follow it to done; lat counts negedges from the one driving req.
  task automatic run(input logic t_we, input logic [1:0] t_size, input logic t_sgn,
                     input logic [31:0] t_addr, input logic [31:0] t_wdata);
    logic prev;
    @(negedge clk);
    req = 1'b1; we = t_we; size = t_size; sgn = t_sgn; addr = t_addr; wdata = t_wdata;
    @(negedge clk);
    // scramble inputs: the access must use the values latched at acceptance
    req = 1'b0; we = ~t_we; size = 2'b11; sgn = ~t_sgn; addr = 32'hFFFF_FFFF; wdata = 32'h0;
    lat = 1;
    cap_sel = sel_o; cap_adr = adr_o; cap_dat = dat_o; cap_we = we_o;
    cyc_seen = cyc_o;
    stb_rise = stb_o ? 1 : 0;
    stb_hi = stb_o ? 1 : 0;
    gaps = 0;
    prev = stb_o;
    while (!done && lat < 1000) begin
      @(negedge clk);
      lat++;
      if (stb_o && !prev) stb_rise++;
      prev = stb_o;
      if (stb_o) stb_hi++;
      if (cyc_o) cyc_seen = 1'b1;
      if (busy && !cyc_o) gaps++;
    end
    check("done_seen", {31'h0, done}, 32'h1);
    check("busy_at_done", {31'h0, busy}, 32'h0);
    res_status = status;
    res_rdata = rdata;
    @(negedge clk);
    check("done_one_cycle", {31'h0, done}, 32'h0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_cyc", {31'h0, cyc_o}, 32'h0);
    check("rst_stb", {31'h0, stb_o}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_sel", {28'h0, sel_o}, 32'h0);
    check("rst_adr", adr_o, 32'h0);
    check("rst_dat", dat_o, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_status", {30'h0, status}, 32'h0);
    rst = 1'b0;

    // word store, zero-wait slave
    mode = M_ACK;
    run(1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF);
    check("ws_sel", {28'h0, cap_sel}, 32'hF);
    check("ws_adr", cap_adr, 32'h10);
    check("ws_we", {31'h0, cap_we}, 32'h1);
    check("ws_dat", cap_dat, 32'hDEAD_BEEF);
    check("ws_latency", lat, 3);
    check("ws_status", {30'h0, res_status}, 32'h0);
    check("ws_rdata", res_rdata, 32'h0);

    // byte loads at offset 3, signed then unsigned
    dat_i = 32'h1122_33F0;
    run(1'b0, 2'b00, 1'b1, 32'h0000_0013, 32'h0);
    check("lbs_sel", {28'h0, cap_sel}, 32'h1);
    check("lbs_adr", cap_adr, 32'h10);
    check("lbs_we", {31'h0, cap_we}, 32'h0);
    check("lbs_rdata", res_rdata, 32'hFFFF_FFF0);
    check("lbs_status", {30'h0, res_status}, 32'h0);
    run(1'b0, 2'b00, 1'b0, 32'h0000_0013, 32'h0);
    check("lbu_rdata", res_rdata, 32'h0000_00F0);
    // rdata holds until the next done
    check("rdata_hold", rdata, 32'h0000_00F0);

    // byte load at offset 1
    run(1'b0, 2'b00, 1'b0, 32'h0000_0011, 32'h0);
    check("lb1_sel", {28'h0, cap_sel}, 32'h4);
    check("lb1_rdata", res_rdata, 32'h0000_0022);

    // half store, upper-address half
    run(1'b1, 2'b01, 1'b0, 32'h0000_0022, 32'h0000_ABCD);
    check("hs_sel", {28'h0, cap_sel}, 32'h3);
    check("hs_dat", cap_dat, 32'hABCD_ABCD);
    check("hs_adr", cap_adr, 32'h20);

    // signed half load, lower-address half
    dat_i = 32'h8001_1234;
    run(1'b0, 2'b01, 1'b1, 32'h0000_0020, 32'h0);
    check("lh_sel", {28'h0, cap_sel}, 32'hC);
    check("lh_rdata", res_rdata, 32'hFFFF_8001);

    // misaligned half load: no bus cycle, done next cycle
    run(1'b0, 2'b01, 1'b0, 32'h0000_0021, 32'h0);
    check("mis_cyc", {31'h0, cyc_seen}, 32'h0);
    check("mis_latency", lat, 1);
    check("mis_status", {30'h0, res_status}, 32'h1);
    check("mis_rdata", res_rdata, 32'h0);

    // reserved size
    run(1'b0, 2'b11, 1'b0, 32'h0000_0000, 32'h0);
    check("rsv_status", {30'h0, res_status}, 32'h1);

    // retries exhausted
    mode = M_RTY;
    run(1'b0, 2'b10, 1'b0, 32'h0000_0030, 32'h0);
    check("rty_stb_count", stb_rise, 4);
    check("rty_gaps", gaps, 3);
    check("rty_status", {30'h0, res_status}, 32'h2);

    // bus error
    mode = M_ERR;
    run(1'b1, 2'b10, 1'b0, 32'h0000_0034, 32'h1234_5678);
    check("err_latency", lat, 3);
    check("err_status", {30'h0, res_status}, 32'h2);

    // silent slave: timeout
    mode = M_NONE;
    run(1'b0, 2'b10, 1'b0, 32'h0000_0038, 32'h0);
    check("tmo_stb_cycles", stb_hi, 255);
    check("tmo_status", {30'h0, res_status}, 32'h3);

    // reset mid-cycle
    @(negedge clk);
    req = 1'b1; we = 1'b0; size = 2'b10; sgn = 1'b0; addr = 32'h0000_0040;
    @(negedge clk);
    req = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_cyc", {31'h0, cyc_o}, 32'h1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_cyc", {31'h0, cyc_o}, 32'h0);
    check("mid_rst_stb", {31'h0, stb_o}, 32'h0);
    check("mid_rst_busy", {31'h0, busy}, 32'h0);
    begin
      int done_cnt;
      done_cnt = 0;
      repeat (3) begin
        @(negedge clk);
        if (done) done_cnt++;
      end
      rst = 1'b0;
      repeat (2) begin
        @(negedge clk);
        if (done) done_cnt++;
      end
      check("rst_no_done", done_cnt, 0);
    end
    mode = M_ACK;
    dat_i = 32'hCAFE_F00D;
    run(1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0);
    check("post_rst_status", {30'h0, res_status}, 32'h0);
    check("post_rst_rdata", res_rdata, 32'hCAFE_F00D);
    check("post_rst_latency", lat, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
